// File: rtl/sram_ring_reader.sv
// sram_ring_reader: consumer of a single-producer ring buffer held in the
// dual-port core SRAM. Polls the producer head pointer and streams out each
// new word. Writes its tail pointer back so the producer can see free space.
module sram_ring_reader #(
    parameter logic [12:0] BASE_ADDR   = 13'h1000,
    parameter int unsigned DEPTH       = 1024,
    parameter logic [12:0] HEAD_ADDR   = 13'h0FFE,
    parameter logic [12:0] TAIL_ADDR   = 13'h0FFF,
    parameter int unsigned POLL_CYCLES = 16,
    localparam int unsigned PTR_W      = $clog2(DEPTH),
    localparam int unsigned ADDR_W     = 13,
    localparam int unsigned DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    output logic              m_clken,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PTR_W-1:0]  tail_ptr,
    output logic              ptr_error,
    output logic [DATA_W-1:0] words_consumed
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [3:0] {
        S_INIT,
        S_INIT_WR,
        S_IDLE,
        S_RD_HEAD,
        S_WAIT_HEAD,
        S_POLL,
        S_RD_DATA,
        S_WAIT_DATA,
        S_OUT,
        S_WR_TAIL
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [ADDR_W-1:0]   r_m_address;
    logic                r_m_chipselect;
    logic                r_m_write;
    logic [DATA_W-1:0]   r_m_writedata;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic [PTR_W-1:0]    r_tail_ptr;
    logic                r_ptr_error;
    logic [DATA_W-1:0]   r_words_consumed;
    logic [CNT_W-1:0]    r_poll_cnt;

    logic                w_acc_cs;
    logic                w_acc_wr;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic [DATA_W-1:0]   w_acc_wdata;
    logic                w_head_bad;
    logic                w_head_empty;
    logic                w_poll_done;
    logic                w_accept;
    logic [PTR_W-1:0]    w_tail_inc;

    // Head pointer classification and handshake/poll terms
    always_comb begin
        w_head_bad   = (m_readdata >= DATA_W'(DEPTH));
        w_head_empty = (m_readdata[PTR_W-1:0] == r_tail_ptr);
        w_poll_done  = (r_poll_cnt == CNT_W'(POLL_CYCLES - 1));
        w_accept     = (r_state == S_OUT) && r_out_valid && out_ready;
        w_tail_inc   = r_tail_ptr + PTR_W'(1);
    end

    // Next-state logic plus the SRAM access to present in the next cycle
    always_comb begin
        w_next_state = r_state;
        w_acc_cs     = 1'b0;
        w_acc_wr     = 1'b0;
        w_acc_addr   = r_m_address;
        w_acc_wdata  = r_m_writedata;

        case (r_state)
            S_INIT:      if (enable) w_next_state = S_INIT_WR;
            S_INIT_WR:   w_next_state = S_RD_HEAD;
            S_IDLE:      if (enable) w_next_state = S_RD_HEAD;
            S_RD_HEAD:   w_next_state = S_WAIT_HEAD;
            S_WAIT_HEAD: begin
                if (w_head_bad || w_head_empty) w_next_state = S_POLL;
                else                            w_next_state = S_RD_DATA;
            end
            S_POLL:      if (w_poll_done) w_next_state = enable ? S_RD_HEAD : S_IDLE;
            S_RD_DATA:   w_next_state = S_WAIT_DATA;
            S_WAIT_DATA: w_next_state = S_OUT;
            S_OUT:       if (w_accept) w_next_state = S_WR_TAIL;
            S_WR_TAIL:   w_next_state = enable ? S_RD_HEAD : S_IDLE;
            default:     w_next_state = S_INIT;
        endcase

        // Strobes are registered, so they are chosen from the state being entered
        case (w_next_state)
            S_INIT_WR: begin
                w_acc_cs    = 1'b1;
                w_acc_wr    = 1'b1;
                w_acc_addr  = TAIL_ADDR;
                w_acc_wdata = '0;
            end
            S_RD_HEAD: begin
                w_acc_cs   = 1'b1;
                w_acc_addr = HEAD_ADDR;
            end
            S_RD_DATA: begin
                w_acc_cs   = 1'b1;
                w_acc_addr = BASE_ADDR + ADDR_W'(r_tail_ptr);
            end
            S_WR_TAIL: begin
                w_acc_cs    = 1'b1;
                w_acc_wr    = 1'b1;
                w_acc_addr  = TAIL_ADDR;
                w_acc_wdata = DATA_W'(w_tail_inc);
            end
            default: ;
        endcase
    end

    // State, bus strobes and consumer bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_INIT;
            r_m_address      <= '0;
            r_m_chipselect   <= 1'b0;
            r_m_write        <= 1'b0;
            r_m_writedata    <= '0;
            r_out_data       <= '0;
            r_out_valid      <= 1'b0;
            r_tail_ptr       <= '0;
            r_ptr_error      <= 1'b0;
            r_words_consumed <= '0;
            r_poll_cnt       <= '0;
        end else begin
            r_state        <= w_next_state;
            r_m_chipselect <= w_acc_cs;
            r_m_write      <= w_acc_wr;
            r_m_address    <= w_acc_addr;
            r_m_writedata  <= w_acc_wdata;

            if (r_state == S_POLL) r_poll_cnt <= r_poll_cnt + CNT_W'(1);
            else                   r_poll_cnt <= '0;

            if ((r_state == S_WAIT_HEAD) && w_head_bad) r_ptr_error <= 1'b1;

            if (r_state == S_WAIT_DATA) begin
                r_out_data  <= m_readdata;
                r_out_valid <= 1'b1;
            end

            if (w_accept) begin
                r_out_valid      <= 1'b0;
                r_tail_ptr       <= w_tail_inc;
                r_words_consumed <= r_words_consumed + DATA_W'(1);
            end
        end
    end

    assign m_address      = r_m_address;
    assign m_chipselect   = r_m_chipselect;
    assign m_write        = r_m_write;
    assign m_byteenable   = 4'hF;
    assign m_writedata    = r_m_writedata;
    assign m_clken        = 1'b1;
    assign out_data       = r_out_data;
    assign out_valid      = r_out_valid;
    assign tail_ptr       = r_tail_ptr;
    assign ptr_error      = r_ptr_error;
    assign words_consumed = r_words_consumed;

endmodule
